// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI word width, receiver FSM states and bus idle levels.
package spi_pkg;
    localparam int   SPI_WORD_W    = 16;
    localparam logic SPI_CS_IDLE   = 1'b1;
    localparam logic SPI_SCLK_IDLE = 1'b0;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} spi_state_e;
endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: first-word-fall-through FIFO holding received SPI words.
module spi_rx_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic full, wr, rd;
    assign full  = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    // a pop frees the slot a same-cycle push needs, so full only drops without a pop
    assign wr    = push & (~full | pop);
    assign rd    = pop & ~empty;
    assign drop  = push & full & ~pop;
    assign dout  = empty ? '0 : mem[rptr];
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= din;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= wptr + AW'(wr);
            rptr  <= rptr + AW'(rd);
            level <= level + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/spi_rx_deser.sv
// spi_rx_deser: SPI slave receiver rebuilding MSB-first frames into a valid/ready word stream.
module spi_rx_deser
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_WORD_W,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          spi_cs_l,
    input  logic                          spi_clk,
    input  logic                          spi_data,
    output logic [DATA_W-1:0]             dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(DATA_W) + 1;
    logic [SYNC_STAGES-1:0] cs_s, sclk_s, data_s;
    logic [SYNC_STAGES:0] flush;
    logic cs_p, sclk_p, armed;
    logic cs_now, cs_fall, cs_rise, sclk_rise, data_sync;
    spi_state_e state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic xbit, xbit_n, push_q, push_n, err_n, empty;
    assign cs_now    = cs_s[SYNC_STAGES-1];
    assign cs_fall   = cs_p & ~cs_now;
    assign cs_rise   = ~cs_p & cs_now;
    assign sclk_rise = ~sclk_p & sclk_s[SYNC_STAGES-1];
    assign data_sync = data_s[SYNC_STAGES-1];
    // armed only once CS is seen high after the reset values have flushed out,
    // so a frame already running at reset release is never picked up mid-way
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_s   <= {SYNC_STAGES{SPI_CS_IDLE}};
            sclk_s <= {SYNC_STAGES{SPI_SCLK_IDLE}};
            data_s <= '0;
            cs_p   <= SPI_CS_IDLE;
            sclk_p <= SPI_SCLK_IDLE;
            flush  <= '0;
            armed  <= 1'b0;
        end else begin
            cs_s   <= {cs_s[SYNC_STAGES-2:0], spi_cs_l};
            sclk_s <= {sclk_s[SYNC_STAGES-2:0], spi_clk};
            data_s <= {data_s[SYNC_STAGES-2:0], spi_data};
            cs_p   <= cs_now;
            sclk_p <= sclk_s[SYNC_STAGES-1];
            flush  <= {flush[SYNC_STAGES-1:0], 1'b1};
            armed  <= armed | (flush[SYNC_STAGES] & cs_now);
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        xbit_n  = xbit;
        push_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n  = '0;
                xbit_n = 1'b0;
                if (cs_fall && armed) state_n = SHIFT;
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shreg_n = {shreg[DATA_W-2:0], data_sync};
                    cnt_n   = cnt + 1'b1;
                end
                if (cnt_n == CW'(DATA_W)) begin
                    push_n  = 1'b1;
                    state_n = HOLD;
                end
                // the edge above is counted before a same-cycle CS rise is judged
                if (cs_rise) begin
                    err_n   = cnt_n != CW'(DATA_W);
                    state_n = IDLE;
                end
            end
            HOLD: begin
                xbit_n = xbit | sclk_rise;
                if (cs_rise) begin
                    err_n   = xbit | sclk_rise;
                    xbit_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            xbit      <= 1'b0;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            xbit      <= xbit_n;
            push_q    <= push_n;
            frame_err <= err_n;
        end
    end
    assign dout_valid = ~empty;
    spi_rx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .din   (shreg),
        .pop   (dout_valid & dout_ready),
        .dout  (dout),
        .empty (empty),
        .level (fifo_level),
        .drop  (overflow)
    );
endmodule

// File: tb/tb_spi_rx_deser.sv
// tb_spi_rx_deser: scoreboard bench driving SPI frames against a queue-based model of the receiver.
module tb_spi_rx_deser;
    logic clk = 0, reset = 1, spi_cs_l = 1, spi_clk = 0, spi_data = 0, dout_ready = 0;
    logic [15:0] dout;
    logic dout_valid, frame_err, overflow;
    logic [2:0] fifo_level;
    int tests = 0, fails = 0, err_seen = 0, ovf_seen = 0, exp_err = 0, exp_ovf = 0;
    logic [15:0] exp_q[$];
    logic [15:0] words [4] = '{16'h1ADC, 16'h1B38, 16'h2648, 16'h26F7};

    always #5 clk = ~clk;

    spi_rx_deser #(.DATA_W(16), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .spi_cs_l(spi_cs_l), .spi_clk(spi_clk), .spi_data(spi_data),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .frame_err(frame_err), .overflow(overflow), .fifo_level(fifo_level)
    );

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) err_seen++;
            if (overflow) ovf_seen++;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) check("unexpected_word", int'(dout), -1);
                else check("word", int'(dout), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_push(logic [15:0] w);
        if (!dout_ready && exp_q.size() == 4) exp_ovf++;
        else exp_q.push_back(w);
    endtask

    task automatic shift_bits(logic [15:0] w, int first, int last, int h);
        for (int i = first; i < last; i++) begin
            spi_data = (i < 16) ? w[15-i] : 1'($urandom);
            cycles(h);
            spi_clk = 1;
            if (i == 15) model_push(w);
            cycles(h);
            spi_clk = 0;
        end
    endtask

    task automatic send_frame(logic [15:0] w, int nbits);
        int h;
        h = $urandom_range(3, 6);
        spi_cs_l = 0;
        cycles(h);
        shift_bits(w, 0, nbits, h);
        cycles(h);
        spi_cs_l = 1;
        if (nbits != 16) exp_err++;
        cycles(h + 6);
    endtask

    task automatic drain();
        dout_ready = 1;
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycles(1);
        check("drain", exp_q.size(), 0);
        cycles(2);
    endtask

    task automatic check_status(string tag);
        check({tag, "_frame_err"}, err_seen, exp_err);
        check({tag, "_overflow"}, ovf_seen, exp_ovf);
    endtask

    initial begin
        cycles(3);
        check("rst_dout", int'(dout), 0);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overflow", int'(overflow), 0);
        reset = 0;
        cycles(5);

        dout_ready = 1;
        send_frame(16'h0A77, 16);
        check("single_popped", exp_q.size(), 0);
        check("single_level", int'(fifo_level), 0);
        check_status("single");

        dout_ready = 0;
        foreach (words[i]) send_frame(words[i], 16);
        check("b2b_level", int'(fifo_level), 4);
        check("b2b_head", int'(dout), 16'h1ADC);
        drain();
        check("b2b_level_after", int'(fifo_level), 0);

        dout_ready = 0;
        foreach (words[i]) send_frame(words[i], 16);
        send_frame(16'h1234, 16);
        check("ovf_count", ovf_seen, 1);
        check("ovf_level", int'(fifo_level), 4);
        check("ovf_head", int'(dout), 16'h1ADC);
        drain();
        check_status("ovf");

        send_frame(16'hFFFF, 9);
        check("short_err", err_seen, 1);
        check("short_level", int'(fifo_level), 0);
        send_frame(16'h00FF, 16);
        drain();
        check_status("short");

        send_frame(16'hBEEF, 17);
        check("long_err", err_seen, 2);
        drain();
        check_status("long");

        dout_ready = 0;
        send_frame(16'h1234, 16);
        check("prerst_level", int'(fifo_level), 1);
        spi_cs_l = 0;
        cycles(4);
        shift_bits(16'h5A5A, 0, 8, 4);
        reset = 1;
        exp_q.delete();
        cycles(3);
        check("midrst_level", int'(fifo_level), 0);
        reset = 0;
        shift_bits(16'h5A5A, 16, 24, 4);
        cycles(4);
        spi_cs_l = 1;
        cycles(12);
        check("postrst_level", int'(fifo_level), 0);
        check("postrst_valid", int'(dout_valid), 0);
        check_status("postrst");
        dout_ready = 1;
        send_frame(16'hA5A5, 16);
        drain();
        check_status("a5a5");

        for (int n = 0; n < 40; n++) begin
            int r, nb;
            r = $urandom_range(0, 9);
            nb = (r < 6) ? 16 : (r < 8) ? $urandom_range(1, 15) : $urandom_range(17, 19);
            dout_ready = $urandom_range(0, 2) != 0 ? 1'b0 : 1'b1;
            send_frame(16'($urandom), nb);
        end
        drain();
        check_status("random");
        check("random_level", int'(fifo_level), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_rx_deser.md
# spi_rx_deser

Slave-side SPI receiver that sits directly downstream of the SPI_STATE master. It consumes `spi_cs_l`, `spi_clk` and `spi_data` and rebuilds each 16-bit frame, MSB first. Completed words are buffered in a small FIFO and presented on a valid/ready stream. Malformed frames and FIFO overflow are flagged on single-cycle status outputs.

## Interface
- `DATA_W`, 16, frame/word width in bits
- `SYNC_STAGES`, 2, synchronizer flops on each SPI input (min 2)
- `FIFO_DEPTH`, 4, output FIFO entries (power of 2)
- `clk` in 1 — system clock; all logic on rising edge
- `reset` in 1 — asynchronous, active-high reset
- `spi_cs_l` in 1 — frame select, active low, asynchronous to `clk`
- `spi_clk` in 1 — SPI serial clock, idles low, asynchronous to `clk`
- `spi_data` in 1 — serial data, MSB first
- `dout` out DATA_W — head-of-FIFO word
- `dout_valid` out 1 — `dout` holds a valid word
- `dout_ready` in 1 — consumer accepts the word when `dout_valid & dout_ready`
- `frame_err` out 1 — one-cycle pulse: frame ended with bit count ≠ DATA_W
- `overflow` out 1 — one-cycle pulse: complete word dropped, FIFO full
- `fifo_level` out $clog2(FIFO_DEPTH)+1 — words currently held

## Operation
- All three SPI inputs pass through SYNC_STAGES flops. A rising edge of `spi_clk` is detected from the last two synchronized samples. `cs_fall` and `cs_rise` are detected the same way.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE: bit counter = 0. On `cs_fall`, go to SHIFT.
  - SHIFT: on each `spi_clk` rise, shift `{shreg[DATA_W-2:0], data_sync}` and increment the counter.
    - When the DATA_W-th bit is shifted: push the word into the FIFO and go to HOLD.
    - On `cs_rise` with counter < DATA_W: pulse `frame_err`, discard the partial word, go to IDLE.
  - HOLD: waiting for `cs_rise`, then go to IDLE.
    - Any `spi_clk` rise in HOLD sets a sticky extra-bit flag.
    - On `cs_rise`, if the flag is set, pulse `frame_err`. The already-pushed word is kept. Clear the flag.
- A `spi_clk` rise while CS is high (IDLE) is ignored.
- `cs_rise` and `spi_clk` rise in the same cycle: the edge is shifted first, then the CS rise is evaluated on the updated count.
- FIFO is first-word-fall-through:
  - `dout` is valid whenever `fifo_level` > 0.
  - Pop on `dout_valid & dout_ready`.
  - Push and pop in the same cycle with level = FIFO_DEPTH: both succeed, no overflow.
  - Push with level = FIFO_DEPTH and no pop: word dropped, `overflow` pulses, FIFO contents unchanged.
- Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The level counter saturates at 0 and FIFO_DEPTH.

## Timing
- Reset values:
  - `dout` = 0, `dout_valid` = 0, `frame_err` = 0, `overflow` = 0, `fifo_level` = 0.
  - FSM = IDLE, shift register = 0, counter = 0.
  - Synchronizer flops reset to their idle levels: `cs` = 1, `clk` = 0, `data` = 0.
- Reset mid-frame aborts the frame without a `frame_err` pulse and empties the FIFO. After reset releases, the receiver waits for a fresh `cs_fall`; a frame already in progress is not resumed.
- Latency: the DATA_W-th `spi_clk` rise is detected at cycle T. The FIFO write happens at T+1. `dout_valid` rises at T+2 if the FIFO was empty.
- Input constraint: `spi_clk` high and low phases are each ≥ SYNC_STAGES+1 `clk` periods. `spi_data` is stable for the same window around each rising edge. The master's clock divider must meet this constraint.
- `frame_err` and `overflow` are high for exactly one `clk` cycle per event.

## Structure
- Package `spi_pkg` holds:
  - `SPI_WORD_W` = 16
  - FSM state enum {IDLE, SHIFT, HOLD}
  - shared CS/SCLK idle-level constants, also used by the master
- Sub-module `spi_rx_fifo` (FIFO_DEPTH × DATA_W, FWFT, push/pop/full/empty/level), instantiated once.
- Synchronizers and edge detectors stay inline in `spi_rx_deser`.

## Test plan
- Single frame 16'd2679 (0x0A77) sent MSB first, `dout_ready` = 1 → `dout` = 0x0A77 with `dout_valid` for 1 cycle, `fifo_level` returns to 0, no status pulses.
- Back-to-back frames 6876, 6968, 9800, 9975 with `dout_ready` = 0 → `fifo_level` = 4. Then raise `dout_ready` → words pop out in order 0x1ADC, 0x1B38, 0x2648, 0x26F7.
- Five frames with `dout_ready` = 0 → fifth frame pulses `overflow` once, `fifo_level` stays 4, head remains 0x1ADC.
- CS raised after 9 bits → `frame_err` pulses once, nothing pushed. Next full frame 0x00FF is received correctly.
- 17 `spi_clk` rises in one frame → word from the first 16 bits is pushed, and `frame_err` pulses at CS rise.
- `reset` asserted after bit 8 of a frame, released while CS is still low → no output and no `frame_err`. Next complete frame 0xA5A5 is received intact.
